reflector_cfg: RTL and testbench



---
 rtl/enigma_pkg.sv | 11 +
 rtl/reflector_table.sv | 36 +++
 rtl/reflector_cfg.sv | 96 +++++++++
 tb/tb_reflector_cfg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg: shared FSM state type, default reflector parameters and char-to-index helper
package enigma_pkg;
  typedef enum logic [2:0] {UNCFG, LOAD, CHECK, READY, ERROR} state_t;
  localparam int N_DEF = 26;
  localparam int W_DEF = 8;
  localparam int BASE_DEF = 65;
  // Index of a character relative to base, wrapped modulo 2^w.
  function automatic int unsigned char_idx(input int unsigned c, input int unsigned base, input int unsigned w);
    return (c - base) & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/reflector_table.sv
// reflector_table: N-entry forward/inverse wiring arrays
// ports: clk; wr_en/wr_idx/wr_val load write; chk_idx -> chk_fwd/chk_back check read; lk_char -> lk_fwd/lk_inv lookup read
module reflector_table
  import enigma_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_val,
  input  logic [IW-1:0] chk_idx,
  output logic [W-1:0]  chk_fwd,
  output logic [W-1:0]  chk_back,
  input  logic [W-1:0]  lk_char,
  output logic [W-1:0]  lk_fwd,
  output logic [IW-1:0] lk_inv
);
  logic [W-1:0]  fwd [N];
  logic [IW-1:0] inv [N];
  logic          lk_in;
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fwd[wr_idx] <= wr_val;
      if (32'(wr_val) < N) inv[wr_val[IW-1:0]] <= wr_idx;
    end
  end
  assign chk_fwd  = fwd[chk_idx];
  // second hop only meaningful when the first lands inside the table; out-of-range already fails the check
  assign chk_back = (32'(chk_fwd) < N) ? fwd[chk_fwd[IW-1:0]] : '0;
  assign lk_in    = 32'(lk_char) < N;
  assign lk_fwd   = lk_in ? fwd[lk_char[IW-1:0]] : '0;
  assign lk_inv   = lk_in ? inv[lk_char[IW-1:0]] : '0;
endmodule

// File: rtl/reflector_cfg.sv
// reflector_cfg: runtime-loadable Enigma reflector with self-check and valid/ready lookup
// ports: clk, reset; load_start/load_valid/load_data serial table load; cfg_ok/cfg_err/err_idx status;
//        in_valid/in_ready/in_char/dec lookup request; out_valid/out_ready/out_char/out_oor registered result
module reflector_cfg
  import enigma_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int BASE = BASE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [W-1:0]         load_data,
  output logic                 cfg_ok,
  output logic                 cfg_err,
  output logic [$clog2(N)-1:0] err_idx,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_char,
  input  logic                 dec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_char,
  output logic                 out_oor
);
  localparam int IW = $clog2(N);
  state_t        state, state_nx;
  logic [IW-1:0] cnt, cnt_nx, err_idx_nx;
  logic          cfg_ok_nx, cfg_err_nx;
  logic [W-1:0]  ld_val, k, chk_fwd, chk_back, lk_fwd;
  logic [IW-1:0] lk_inv;
  logic          ld_acc, last, chk_fail, oor, acc;
  assign ld_val   = W'(char_idx(32'(load_data), BASE, W));
  assign k        = W'(char_idx(32'(in_char), BASE, W));
  assign ld_acc   = state == LOAD && load_valid && !load_start;
  assign last     = cnt == IW'(N - 1);
  assign chk_fail = 32'(chk_fwd) >= N || chk_fwd == W'(cnt) || chk_back != W'(cnt);
  assign oor      = 32'(in_char) < BASE || 32'(in_char) >= BASE + N;
  assign in_ready = state == READY && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  reflector_table #(.N(N), .W(W)) u_table (
    .clk(clk), .wr_en(ld_acc), .wr_idx(cnt), .wr_val(ld_val),
    .chk_idx(cnt), .chk_fwd(chk_fwd), .chk_back(chk_back),
    .lk_char(k), .lk_fwd(lk_fwd), .lk_inv(lk_inv)
  );
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cfg_ok_nx  = cfg_ok;
    cfg_err_nx = cfg_err;
    err_idx_nx = err_idx;
    if (load_start) begin
      state_nx   = LOAD;
      cnt_nx     = '0;
      cfg_ok_nx  = 1'b0;
      cfg_err_nx = 1'b0;
    end else if (ld_acc) begin
      state_nx = last ? CHECK : LOAD;
      cnt_nx   = last ? '0 : cnt + 1'b1;
    end else if (state == CHECK) begin
      if (chk_fail) begin
        state_nx   = ERROR;
        cfg_err_nx = 1'b1;
        err_idx_nx = cnt;
      end else if (last) begin
        state_nx  = READY;
        cfg_ok_nx = 1'b1;
      end else cnt_nx = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNCFG;
      cnt       <= '0;
      cfg_ok    <= 1'b0;
      cfg_err   <= 1'b0;
      err_idx   <= '0;
      out_valid <= 1'b0;
      out_char  <= '0;
      out_oor   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cfg_ok  <= cfg_ok_nx;
      cfg_err <= cfg_err_nx;
      err_idx <= err_idx_nx;
      if (acc) begin
        out_valid <= 1'b1;
        out_oor   <= oor;
        out_char  <= oor ? in_char : W'(BASE) + (dec ? W'(lk_inv) : lk_fwd);
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reflector_cfg.sv
// tb_reflector_cfg: scoreboard bench for reflector_cfg with directed vectors
module tb_reflector_cfg;
  logic       clk = 0, reset = 1, load_start = 0, load_valid = 0;
  logic       in_valid = 0, dec = 0, out_ready = 1;
  logic [7:0] load_data = 0, in_char = 0;
  logic       cfg_ok, cfg_err, in_ready, out_valid, out_oor;
  logic [4:0] err_idx;
  logic [7:0] out_char;
  int vecs = 0, miss = 0;
  typedef struct {logic [7:0] c; logic o;} exp_t;
  exp_t q[$];
  string ukwb  = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  string bad_a = "ARUHQSLDPXNGOKMIEBFZCWVJAT";
  string bad_b = "BCUHQSLDPXNGOKMIEBFZCWVJAT";
  string bad_c = "YRUHQSLDPXNGOKMIEBFZAWVJAT";
  string pairs = "BADCFEHGJILKNMPORQTSVUXWZY";

  reflector_cfg #(.N(26), .W(8), .BASE(65)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .cfg_ok(cfg_ok), .cfg_err(cfg_err), .err_idx(err_idx),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .dec(dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .out_oor(out_oor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vecs++;
        miss++;
        $display("FAIL unexpected_output: got %0d expected none", out_char);
      end else begin
        e = q.pop_front();
        chk("out_char", int'(out_char), int'(e.c));
        chk("out_oor", int'(out_oor), int'(e.o));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic d, input logic [7:0] e, input logic o);
    int n = 0;
    in_valid = 1;
    in_char = c;
    dec = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vecs++;
      miss++;
      $display("FAIL accept_timeout: in_ready got 0 required 1 for char %0d", c);
      in_valid = 0;
      return;
    end
    q.push_back('{c: e, o: o});
    step();
    in_valid = 0;
  endtask

  task automatic load(input string s, input bit start);
    if (start) begin
      load_start = 1;
      step();
      load_start = 0;
    end
    load_valid = 1;
    for (int i = 0; i < s.len(); i++) begin
      load_data = s[i];
      step();
    end
    load_valid = 0;
  endtask

  task automatic wait_cfg(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!cfg_ok && !cfg_err && k < 100);
  endtask

  task automatic no_accept(input string name);
    in_valid = 1;
    in_char = "A";
    repeat (3) begin
      @(negedge clk);
      chk({name, "_in_ready"}, int'(in_ready), 0);
      chk({name, "_out_valid"}, int'(out_valid), 0);
    end
    step();
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ok", int'(cfg_ok), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_err_idx", int'(err_idx), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_char", int'(out_char), 0);
    chk("rst_out_oor", int'(out_oor), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    reset = 0;
    step();

    load(ukwb, 1);
    wait_cfg(k);
    chk("ukwb_latency", k, 26);
    chk("ukwb_cfg_ok", int'(cfg_ok), 1);
    chk("ukwb_cfg_err", int'(cfg_err), 0);
    send("A", 0, "Y", 0);
    @(negedge clk); chk("lat_A", int'(out_valid), 1); step();
    send("Y", 0, "A", 0);
    @(negedge clk); chk("lat_Y", int'(out_valid), 1); step();
    send("Z", 0, "T", 0);
    @(negedge clk); chk("lat_Z", int'(out_valid), 1); step();
    send("C", 1, "U", 0);
    send("C", 0, "U", 0);
    send(8'd97, 0, 8'd97, 1);
    send("@", 0, "@", 1);
    send("[", 0, "[", 1);
    repeat (2) step();

    out_ready = 0;
    fork
      begin
        send("A", 0, "Y", 0);
        send("B", 0, "R", 0);
        send("C", 0, "U", 0);
        send("D", 0, "H", 0);
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_char", int'(out_char), int'("Y"));
          chk("stall_ready", int'(in_ready), 0);
        end
        step();
        out_ready = 1;
      end
    join
    repeat (2) step();

    in_valid = 1;
    in_char = "C";
    dec = 0;
    load_start = 1;
    @(negedge clk);
    chk("start_lookup_ready", int'(in_ready), 1);
    q.push_back('{c: "U", o: 0});
    step();
    in_valid = 0;
    load_start = 0;
    chk("ready_after_start", int'(in_ready), 0);
    chk("cfg_ok_after_start", int'(cfg_ok), 0);
    load(pairs, 0);
    wait_cfg(k);
    chk("pairs_latency", k, 26);
    chk("pairs_cfg_ok", int'(cfg_ok), 1);
    send("A", 0, "B", 0);
    send("C", 1, "D", 0);
    repeat (2) step();

    load(bad_a, 1);
    wait_cfg(k);
    chk("bad_a_latency", k, 1);
    chk("bad_a_cfg_err", int'(cfg_err), 1);
    chk("bad_a_err_idx", int'(err_idx), 0);
    chk("bad_a_cfg_ok", int'(cfg_ok), 0);
    no_accept("bad_a");

    load(bad_b, 1);
    wait_cfg(k);
    chk("bad_b_cfg_err", int'(cfg_err), 1);
    chk("bad_b_err_idx", int'(err_idx), 0);

    load(bad_c, 1);
    wait_cfg(k);
    chk("bad_c_latency", k, 3);
    chk("bad_c_cfg_err", int'(cfg_err), 1);
    chk("bad_c_err_idx", int'(err_idx), 2);

    load(ukwb, 1);
    wait_cfg(k);
    chk("reload_cfg_ok", int'(cfg_ok), 1);
    chk("reload_cfg_err", int'(cfg_err), 0);

    load(ukwb.substr(0, 9), 1);
    reset = 1;
    step();
    reset = 0;
    chk("midrst_cfg_ok", int'(cfg_ok), 0);
    chk("midrst_cfg_err", int'(cfg_err), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    no_accept("midrst");
    load(ukwb, 0);
    wait_cfg(k);
    chk("no_start_cfg_ok", int'(cfg_ok), 0);

    repeat (3) step();
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
